// File: rtl/dmem_ctrl_if.sv
// Bus bundle between the two requesters (core LSU, debug/DMA), dmem_ctrl and the data RAM.
// The master modport is the requester/RAM side and the slave modport is the controller side.
interface dmem_ctrl_if #(parameter int MEM_AW = 10);
   logic              req_c;
   logic              we_c;
   logic [2:0]        funct3_c;
   logic [31:0]       addr_c;
   logic [31:0]       wdata_c;
   logic              req_d;
   logic              we_d;
   logic [2:0]        funct3_d;
   logic [31:0]       addr_d;
   logic [31:0]       wdata_d;
   logic              done_c;
   logic              done_d;
   logic [31:0]       rdata;
   logic              err;
   logic              busy;
   logic [MEM_AW-1:0] mem_addr;
   logic              mem_re;
   logic              mem_we;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   modport master (
      output req_c, we_c, funct3_c, addr_c, wdata_c,
      output req_d, we_d, funct3_d, addr_d, wdata_d,
      output mem_rdata,
      input  done_c, done_d, rdata, err, busy,
      input  mem_addr, mem_re, mem_we, mem_wdata
   );

   modport slave (
      input  req_c, we_c, funct3_c, addr_c, wdata_c,
      input  req_d, we_d, funct3_d, addr_d, wdata_d,
      input  mem_rdata,
      output done_c, done_d, rdata, err, busy,
      output mem_addr, mem_re, mem_we, mem_wdata
   );
endinterface

// File: rtl/dmem_ctrl.sv
// Data memory sequencer: arbitrates core/debug ports and runs RV32 loads/stores with SB/SH read-modify-write.
// Optional macro MISALIGN_TRAP_EN: trap misaligned half/word accesses with err instead of ignoring the low bits.
module dmem_ctrl #(
   parameter int MEM_AW     = 10,
   parameter bit PRIO_FIXED = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   dmem_ctrl_if.slave bus
);

   typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_WAIT, S_WRITE, S_DONE} state_t;

   state_t            state, state_n;
   logic              last_d;
   logic              win_d;
   logic              op_we;
   logic [2:0]        op_f3;
   logic [MEM_AW+1:0] op_addr;
   logic [31:0]       op_wdata;
   logic              err_q;
   logic [31:0]       rdata_q;
   logic [31:0]       merged_q;

   logic              any_req;
   logic              pick_d;
   logic              sel_we;
   logic [2:0]        sel_f3;
   logic [31:0]       sel_addr;
   logic [31:0]       sel_wdata;
   logic              sel_illegal;
   logic              sel_misalign;
   logic              unused_addr_hi;

   logic [7:0]        lane_b;
   logic [15:0]       lane_h;
   logic [31:0]       load_ext;
   logic [31:0]       merged_w;

   // Winner selection for the IDLE cycle; last_d remembers who was served last for round-robin ties.
   always_comb begin
      any_req   = bus.req_c || bus.req_d;
      pick_d    = bus.req_d && (!bus.req_c || (!PRIO_FIXED && !last_d));
      sel_we    = pick_d ? bus.we_d     : bus.we_c;
      sel_f3    = pick_d ? bus.funct3_d : bus.funct3_c;
      sel_addr  = pick_d ? bus.addr_d   : bus.addr_c;
      sel_wdata = pick_d ? bus.wdata_d  : bus.wdata_c;
      if (sel_we)
         sel_illegal = sel_f3[2] || (sel_f3[1:0] == 2'b11);
      else
         sel_illegal = (sel_f3 == 3'b011) || (sel_f3[2:1] == 2'b11);
`ifdef MISALIGN_TRAP_EN
      sel_misalign = 1'b0;
      if (!sel_illegal) begin
         if (sel_f3[1:0] == 2'b01)
            sel_misalign = sel_addr[0];
         else if (sel_f3[1:0] == 2'b10)
            sel_misalign = |sel_addr[1:0];
      end
`else
      sel_misalign = 1'b0;
`endif
   end

   // Address bits above the RAM size wrap around and are deliberately dropped.
   assign unused_addr_hi = ^sel_addr[31:MEM_AW+2];

   // Lane extraction for loads and lane merge for SB/SH, both from the word read in WAIT.
   always_comb begin
      lane_b = bus.mem_rdata[{op_addr[1:0], 3'b000} +: 8];
      lane_h = op_addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
      case (op_f3)
         3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
         3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
         3'b100:  load_ext = {24'h0, lane_b};
         3'b101:  load_ext = {16'h0, lane_h};
         default: load_ext = bus.mem_rdata;
      endcase
      merged_w = bus.mem_rdata;
      if (op_f3[0])
         merged_w[{op_addr[1], 4'b0000} +: 16] = op_wdata[15:0];
      else
         merged_w[{op_addr[1:0], 3'b000} +: 8] = op_wdata[7:0];
   end

   // State register plus the transaction fields captured at grant time.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         last_d   <= 1'b1;
         win_d    <= 1'b0;
         op_we    <= 1'b0;
         op_f3    <= 3'b000;
         op_addr  <= '0;
         op_wdata <= 32'h0;
         err_q    <= 1'b0;
         rdata_q  <= 32'h0;
         merged_q <= 32'h0;
      end else begin
         state <= state_n;
         case (state)
            S_IDLE: begin
               if (any_req) begin
                  win_d    <= pick_d;
                  last_d   <= pick_d;
                  op_we    <= sel_we;
                  op_f3    <= sel_f3;
                  op_addr  <= sel_addr[MEM_AW+1:0];
                  op_wdata <= sel_wdata;
                  err_q    <= sel_illegal || sel_misalign;
                  rdata_q  <= 32'h0;
               end
            end
            S_WAIT: begin
               if (op_we)
                  merged_q <= merged_w;
               else
                  rdata_q <= load_ext;
            end
            default: ;
         endcase
      end
   end

   // Next state and RAM strobes; SW writes straight from ACCESS, SB/SH go through WAIT and WRITE.
   always_comb begin
      state_n       = state;
      bus.mem_re    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_wdata = 32'h0;
      case (state)
         S_IDLE: begin
            if (any_req)
               state_n = sel_misalign ? S_DONE : S_ACCESS;
         end
         S_ACCESS: begin
            if (err_q) begin
               state_n = S_DONE;
            end else if (op_we && (op_f3 == 3'b010)) begin
               bus.mem_we    = 1'b1;
               bus.mem_wdata = op_wdata;
               state_n       = S_DONE;
            end else begin
               bus.mem_re = 1'b1;
               state_n    = S_WAIT;
            end
         end
         S_WAIT:  state_n = op_we ? S_WRITE : S_DONE;
         S_WRITE: begin
            bus.mem_we    = 1'b1;
            bus.mem_wdata = merged_q;
            state_n       = S_DONE;
         end
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   assign bus.mem_addr = op_addr[MEM_AW+1:2];
   assign bus.busy     = (state != S_IDLE);
   assign bus.done_c   = (state == S_DONE) && !win_d;
   assign bus.done_d   = (state == S_DONE) && win_d;
   assign bus.rdata    = (state == S_DONE) ? rdata_q : 32'h0;
   assign bus.err      = (state == S_DONE) && err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: round-robin and fixed-priority instances backed by behavioural RAMs.
// Expected values are hand-computed per vector; follows MISALIGN_TRAP_EN the same way the design does.
module tb_dmem_ctrl;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   dmem_ctrl_if #(.MEM_AW(10)) bus ();
   dmem_ctrl_if #(.MEM_AW(10)) bus2 ();

   dmem_ctrl #(.MEM_AW(10), .PRIO_FIXED(1'b0)) dut  (.clk(clk), .rst(rst), .bus(bus));
   dmem_ctrl #(.MEM_AW(10), .PRIO_FIXED(1'b1)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural synchronous-read RAM with a backdoor poke port and event counters.
   logic [31:0] ram [0:1023];
   logic [31:0] ram_q = 32'h0;
   logic        poke_en = 1'b0;
   logic [9:0]  poke_addr = 10'h0;
   logic [31:0] poke_data = 32'h0;
   int          we_cnt = 0;
   int          done_cnt = 0;
   int          excl_viol = 0;
   logic [9:0]  last_we_addr = 10'h0;
   logic [31:0] last_we_data = 32'h0;

   always @(posedge clk) begin
      if (poke_en) ram[poke_addr] <= poke_data;
      if (bus.mem_we) begin
         ram[bus.mem_addr] <= bus.mem_wdata;
         we_cnt       <= we_cnt + 1;
         last_we_addr <= bus.mem_addr;
         last_we_data <= bus.mem_wdata;
      end
      if (bus.mem_re) ram_q <= ram[bus.mem_addr];
      if (bus.mem_we && bus.mem_re) excl_viol <= excl_viol + 1;
      if (bus2.mem_we && bus2.mem_re) excl_viol <= excl_viol + 1;
      if (bus.done_c || bus.done_d) done_cnt <= done_cnt + 1;
   end
   assign bus.mem_rdata = ram_q;

   // Second RAM returns a word derived from its address: 0x1000 + word index.
   logic [31:0] ram2_q = 32'h0;
   always @(posedge clk) begin
      if (bus2.mem_re) ram2_q <= {22'h0, bus2.mem_addr} + 32'h1000;
   end
   assign bus2.mem_rdata = ram2_q;

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic pokeRam(input logic [9:0] a, input logic [31:0] d);
      @(negedge clk);
      poke_en   = 1'b1;
      poke_addr = a;
      poke_data = d;
      @(posedge clk);
      #1;
      poke_en = 1'b0;
   endtask

   // One transaction on port c or d; latency counts rising edges from request to the done pulse.
   task automatic applyStimulus(input bit pd, input bit we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output int lat, output logic [1:0] who,
                                output logic [31:0] rd, output logic er);
      @(negedge clk);
      if (pd) begin
         bus.req_d = 1'b1; bus.we_d = we; bus.funct3_d = f3; bus.addr_d = addr; bus.wdata_d = wdata;
      end else begin
         bus.req_c = 1'b1; bus.we_c = we; bus.funct3_c = f3; bus.addr_c = addr; bus.wdata_c = wdata;
      end
      lat = 0;
      who = 2'b00;
      rd  = 32'h0;
      er  = 1'b0;
      while (lat < 12 && who == 2'b00) begin
         @(posedge clk);
         #1;
         lat++;
         if (bus.done_c || bus.done_d) begin
            who = {bus.done_d, bus.done_c};
            rd  = bus.rdata;
            er  = bus.err;
         end
      end
      bus.req_c = 1'b0;
      bus.req_d = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic runOp(input string tag, input bit pd, input bit we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata, input int exp_lat,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_we);
      int          lat;
      logic [1:0]  who;
      logic [31:0] rd;
      logic        er;
      int          we0;
      we0 = we_cnt;
      applyStimulus(pd, we, f3, addr, wdata, lat, who, rd, er);
      checkOutput({tag, "_latency"}, lat, exp_lat);
      checkOutput({tag, "_port"}, {30'h0, who}, pd ? 32'd2 : 32'd1);
      checkOutput({tag, "_rdata"}, rd, exp_rd);
      checkOutput({tag, "_err"}, {31'h0, er}, {31'h0, exp_err});
      checkOutput({tag, "_we_count"}, we_cnt - we0, exp_we);
      checkOutput({tag, "_done_once"}, {30'h0, bus.done_d, bus.done_c}, 32'h0);
      checkOutput({tag, "_idle_after"}, {31'h0, bus.busy}, 32'h0);
   endtask

   initial begin
      logic [31:0] rdv [4];
      logic        whov [4];
      int          n;
      int          cyc;
      int          we0;
      int          d0;

      bus.req_c = 1'b0; bus.we_c = 1'b0; bus.funct3_c = 3'b0; bus.addr_c = 32'h0; bus.wdata_c = 32'h0;
      bus.req_d = 1'b0; bus.we_d = 1'b0; bus.funct3_d = 3'b0; bus.addr_d = 32'h0; bus.wdata_d = 32'h0;
      bus2.req_c = 1'b0; bus2.we_c = 1'b0; bus2.funct3_c = 3'b0; bus2.addr_c = 32'h0; bus2.wdata_c = 32'h0;
      bus2.req_d = 1'b0; bus2.we_d = 1'b0; bus2.funct3_d = 3'b0; bus2.addr_d = 32'h0; bus2.wdata_d = 32'h0;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_busy", {31'h0, bus.busy}, 32'h0);
      checkOutput("reset_done", {30'h0, bus.done_d, bus.done_c}, 32'h0);
      checkOutput("reset_rdata", bus.rdata, 32'h0);
      checkOutput("reset_err", {31'h0, bus.err}, 32'h0);
      checkOutput("reset_mem_we", {31'h0, bus.mem_we}, 32'h0);
      checkOutput("reset_mem_re", {31'h0, bus.mem_re}, 32'h0);
      checkOutput("reset_mem_addr", {22'h0, bus.mem_addr}, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Both ports hold LW from reset: c must win the first tie, then grants alternate.
      pokeRam(10'd8, 32'hC0C0C0C0);
      pokeRam(10'd9, 32'hD0D0D0D0);
      @(negedge clk);
      bus.req_c = 1'b1; bus.we_c = 1'b0; bus.funct3_c = 3'b010; bus.addr_c = 32'h20;
      bus.req_d = 1'b1; bus.we_d = 1'b0; bus.funct3_d = 3'b010; bus.addr_d = 32'h24;
      n = 0;
      cyc = 0;
      while (n < 4 && cyc < 60) begin
         @(posedge clk);
         #1;
         cyc++;
         if (bus.done_c || bus.done_d) begin
            whov[n] = bus.done_d;
            rdv[n]  = bus.rdata;
            n++;
         end
      end
      bus.req_c = 1'b0;
      bus.req_d = 1'b0;
      checkOutput("rr_grant_count", n, 4);
      for (int i = 0; i < n; i++) begin
         checkOutput($sformatf("rr_grant%0d", i), {31'h0, whov[i]}, i % 2);
         checkOutput($sformatf("rr_rdata%0d", i), rdv[i], (i % 2) ? 32'hD0D0D0D0 : 32'hC0C0C0C0);
      end
      repeat (2) @(posedge clk);
      #1;

      runOp("sw_c", 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 2, 32'h0, 1'b0, 1);
      checkOutput("sw_c_mem_addr", {22'h0, last_we_addr}, 32'd4);
      checkOutput("sw_c_mem_wdata", last_we_data, 32'hDEADBEEF);
      checkOutput("sw_c_ram", ram[4], 32'hDEADBEEF);

      pokeRam(10'd4, 32'h80FF0000);
      runOp("lb", 1'b0, 1'b0, 3'b000, 32'h13, 32'h0, 3, 32'hFFFFFF80, 1'b0, 0);
      runOp("lbu", 1'b0, 1'b0, 3'b100, 32'h13, 32'h0, 3, 32'h00000080, 1'b0, 0);
      runOp("lbu_lane2", 1'b0, 1'b0, 3'b100, 32'h12, 32'h0, 3, 32'h000000FF, 1'b0, 0);
      runOp("lh", 1'b0, 1'b0, 3'b001, 32'h12, 32'h0, 3, 32'hFFFF80FF, 1'b0, 0);
      runOp("lhu", 1'b0, 1'b0, 3'b101, 32'h12, 32'h0, 3, 32'h000080FF, 1'b0, 0);
      runOp("lh_low", 1'b0, 1'b0, 3'b001, 32'h10, 32'h0, 3, 32'h00000000, 1'b0, 0);
      runOp("lw_wrap", 1'b0, 1'b0, 3'b010, 32'h00001010, 32'h0, 3, 32'h80FF0000, 1'b0, 0);

      pokeRam(10'd4, 32'h11223344);
      runOp("sb", 1'b0, 1'b1, 3'b000, 32'h11, 32'hFFFFFFAB, 4, 32'h0, 1'b0, 1);
      checkOutput("sb_mem_addr", {22'h0, last_we_addr}, 32'd4);
      checkOutput("sb_mem_wdata", last_we_data, 32'h1122AB44);
      runOp("sh", 1'b0, 1'b1, 3'b001, 32'h12, 32'h00005566, 4, 32'h0, 1'b0, 1);
      checkOutput("sh_mem_wdata", last_we_data, 32'h5566AB44);
      checkOutput("sh_ram", ram[4], 32'h5566AB44);

      runOp("st_illegal", 1'b0, 1'b1, 3'b011, 32'h20, 32'h1, 2, 32'h0, 1'b1, 0);
      runOp("st_illegal_1xx", 1'b1, 1'b1, 3'b100, 32'h20, 32'h1, 2, 32'h0, 1'b1, 0);
      runOp("ld_illegal", 1'b0, 1'b0, 3'b111, 32'h20, 32'h0, 2, 32'h0, 1'b1, 0);
      checkOutput("illegal_ram_kept", ram[8], 32'hC0C0C0C0);

      pokeRam(10'd0, 32'hCAFEF00D);
`ifdef MISALIGN_TRAP_EN
      runOp("lw_misaligned", 1'b0, 1'b0, 3'b010, 32'h2, 32'h0, 1, 32'h0, 1'b1, 0);
      runOp("lh_misaligned", 1'b0, 1'b0, 3'b001, 32'h1, 32'h0, 1, 32'h0, 1'b1, 0);
`else
      runOp("lw_misaligned", 1'b0, 1'b0, 3'b010, 32'h2, 32'h0, 3, 32'hCAFEF00D, 1'b0, 0);
      runOp("lh_misaligned", 1'b0, 1'b0, 3'b001, 32'h1, 32'h0, 3, 32'hFFFFF00D, 1'b0, 0);
`endif

      runOp("sw_d", 1'b1, 1'b1, 3'b010, 32'h40, 32'h12345678, 2, 32'h0, 1'b0, 1);
      checkOutput("sw_d_mem_addr", {22'h0, last_we_addr}, 32'd16);
      runOp("lw_d", 1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 3, 32'h12345678, 1'b0, 0);

      // Reset lands while the SH is in WAIT: the merge write and the done pulse must both vanish.
      pokeRam(10'd6, 32'hA5A5A5A5);
      we0 = we_cnt;
      d0  = done_cnt;
      @(negedge clk);
      bus.req_c = 1'b1; bus.we_c = 1'b1; bus.funct3_c = 3'b001; bus.addr_c = 32'h18; bus.wdata_c = 32'h7777;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      checkOutput("rmw_busy_before_rst", {31'h0, bus.busy}, 32'h1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("rst_mid_busy", {31'h0, bus.busy}, 32'h0);
      checkOutput("rst_mid_mem_we", {31'h0, bus.mem_we}, 32'h0);
      checkOutput("rst_mid_done", {30'h0, bus.done_d, bus.done_c}, 32'h0);
      rst = 1'b0;
      bus.req_c = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_mid_no_write", we_cnt - we0, 0);
      checkOutput("rst_mid_no_done", done_cnt - d0, 0);
      checkOutput("rst_mid_ram_kept", ram[6], 32'hA5A5A5A5);
      runOp("post_rst_lw", 1'b0, 1'b0, 3'b010, 32'h18, 32'h0, 3, 32'hA5A5A5A5, 1'b0, 0);

      // Fixed-priority instance: c keeps winning while it holds req, d only after c lets go.
      @(negedge clk);
      bus2.req_c = 1'b1; bus2.we_c = 1'b0; bus2.funct3_c = 3'b010; bus2.addr_c = 32'h8;
      bus2.req_d = 1'b1; bus2.we_d = 1'b0; bus2.funct3_d = 3'b010; bus2.addr_d = 32'hC;
      n = 0;
      cyc = 0;
      while (n < 3 && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
         if (bus2.done_c || bus2.done_d) begin
            whov[n] = bus2.done_d;
            rdv[n]  = bus2.rdata;
            n++;
         end
      end
      bus2.req_c = 1'b0;
      checkOutput("prio_grant_count", n, 3);
      for (int i = 0; i < n; i++) begin
         checkOutput($sformatf("prio_grant%0d", i), {31'h0, whov[i]}, 32'h0);
         checkOutput($sformatf("prio_rdata%0d", i), rdv[i], 32'h00001002);
      end
      n = 0;
      cyc = 0;
      while (n == 0 && cyc < 12) begin
         @(posedge clk);
         #1;
         cyc++;
         if (bus2.done_c || bus2.done_d) begin
            whov[0] = bus2.done_d;
            rdv[0]  = bus2.rdata;
            n = 1;
         end
      end
      bus2.req_d = 1'b0;
      checkOutput("prio_d_served", n, 1);
      checkOutput("prio_d_grant", {31'h0, whov[0]}, 32'h1);
      checkOutput("prio_d_rdata", rdv[0], 32'h00001003);

      repeat (2) @(posedge clk);
      #1;
      checkOutput("we_re_exclusive", excl_viol, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
